led_ripple_monitor: RTL
=======================

# led_ripple_monitor

Observer on the receiving end of the LED ripple bus. It samples the 8-bit one-hot `led` pattern that `led_ripple` drives and locks onto the rotation. It then tracks position and counts completed laps, and raises sticky errors on a non-one-hot value, a skipped or backward step, or a stalled pattern. It sits beside `led_ripple` in the board top and in benches as a self-checking consumer.

## Interface
- `WIDTH`, 8: LED bus width; `pos` width is $clog2(WIDTH).
- `DIR`, 0: expected rotation; 0 = bit i→i+1 (MSB wraps to bit 0), 1 = bit i→i−1 (bit 0 wraps to MSB).
- `STEP_TIMEOUT`, 50_000_000: maximum clk cycles allowed between pattern changes.
- `LOCK_STEPS`, 3: consecutive valid steps required to enter LOCKED.
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `led`  in  WIDTH  observed LED bus, synchronous to `clk`.
- `clr_err`  in  1  one-cycle pulse; clears sticky error flags.
- `locked`  out  1  high while in LOCKED.
- `pos`  out  $clog2(WIDTH)  index of the lit LED; valid when `locked`.
- `lap_count`  out  16  completed laps while locked; saturates at 16'hFFFF.
- `err_onehot`  out  1  sticky; a non-one-hot value was seen while locked.
- `err_step`  out  1  sticky; a one-hot value that is not the expected next position was seen while locked.
- `err_timeout`  out  1  sticky; no change for STEP_TIMEOUT cycles while locked.
- `err_count`  out  8  saturating error event count (see Configuration).

## Operation
- `led_q` holds the previous `led` sample. A transition is `led != led_q`. Expected next = `led_q` rotated one place per DIR.
- `stall_cnt` counts cycles since the last transition. It clears on every transition and saturates at STEP_TIMEOUT−1.
- HUNT (reset state): on a transition to a one-hot value → ACQUIRE with `step_cnt`=0. No errors are flagged here.
- ACQUIRE: a valid step increments `step_cnt`. When `step_cnt` reaches LOCK_STEPS → LOCKED, with `pos` = index of current `led`. An invalid transition or a timeout → HUNT silently.
- LOCKED:
  - Valid step: update `pos`. A wrap (pos WIDTH−1→0 for DIR=0, 0→WIDTH−1 for DIR=1) increments `lap_count`.
  - Transition to a non-one-hot value (including all-zero) → set `err_onehot`, go to HUNT.
  - Transition to a one-hot but unexpected value → set `err_step`, go to HUNT.
  - `stall_cnt` == STEP_TIMEOUT−1 with no transition → set `err_timeout`, go to HUNT.
- Leaving LOCKED drops `locked`. `lap_count` holds its value and resumes counting on the next lock; it clears only on reset.
- Simultaneous events:
  - A transition cancels a timeout in the same cycle.
  - `err_onehot` takes priority over `err_step` (exactly one flag per event).
  - `clr_err` coincident with a new error: the new error wins and the flag stays set.

## Timing
- Reset values: state HUNT, `led_q`=0, `locked`=0, `pos`=0, `lap_count`=0, all err flags 0, `err_count`=0, `stall_cnt`=0. Reset asserted mid-operation clears all of these immediately.
- All outputs are registered. A `led` value presented before edge k is judged at edge k, and its effect on outputs is visible after edge k (1-cycle latency).
- Lock latency: `locked` rises on the edge that samples the LOCK_STEPS-th valid step after the first one-hot transition.
- `clr_err` takes effect on the edge where it is sampled high.

## Configuration
- `LED_RIPPLE_MON_ERRCNT_EN` defined: `err_count` increments by 1 (saturating at 255) on each error event in LOCKED; it is not cleared by `clr_err`, only by reset.
- Undefined: no counter logic; `err_count` is tied to 8'd0.

## Structure
- Shared package `led_ripple_pkg`: state enum (HUNT, ACQUIRE, LOCKED), default WIDTH, and the DIR encodings.
- One sub-module, `onehot_check`: combinational is-one-hot flag plus binary index encoder for WIDTH bits.

## Test plan
- Clean ripple, DIR=0, STEP_TIMEOUT=16, 4-cycle steps from 8'h01 → `locked`=1 after 3 steps; `pos` follows 3,4,5…; `lap_count`=1 after 8'h80→8'h01; no error flags.
- While locked, drive 8'h03 → `err_onehot`=1 one cycle later, `locked`=0, `err_count`=1 (macro on).
- While locked at 8'h04, drive 8'h10 → `err_step`=1, `locked`=0; then `clr_err` pulse → flag 0.
- While locked, hold 8'h08 for 16 cycles → `err_timeout`=1 exactly at cycle 16, `locked`=0.
- Assert `rst_n`=0 mid-lap with `lap_count`=5 → all outputs 0 immediately; relock from HUNT after release.
- DIR=1 with a left-shifting stimulus → never locks; no error flags.

Source files
------------

// File: rtl/led_ripple_pkg.sv
// Shared definitions for the LED ripple bus: monitor FSM states, default bus
// width and the rotation-direction encodings.
package led_ripple_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  localparam int DIR_UP   = 0;
  localparam int DIR_DOWN = 1;

endpackage

// File: rtl/led_ripple_monitor_onehot_check.sv
// Combinational one-hot detector and binary index encoder for the LED bus.
module onehot_check #(
  parameter int WIDTH = 8,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic             is_onehot,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    is_onehot = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);
    idx       = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/led_ripple_monitor.sv
// Receive-side observer for the LED ripple bus: locks onto the rotation, tracks
// position and laps, and raises sticky errors. Optional error counter: LED_RIPPLE_MON_ERRCNT_EN.
module led_ripple_monitor
  import led_ripple_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int DIR          = DIR_UP,
  parameter int STEP_TIMEOUT = 50_000_000,
  parameter int LOCK_STEPS   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         led,
  input  logic                     clr_err,
  output logic                     locked,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic [15:0]              lap_count,
  output logic                     err_onehot,
  output logic                     err_step,
  output logic                     err_timeout,
  output logic [7:0]               err_count
);

  localparam int POS_W = $clog2(WIDTH);
  localparam int ST_W  = (STEP_TIMEOUT > 2) ? $clog2(STEP_TIMEOUT) : 1;
  localparam int SC_W  = $clog2(LOCK_STEPS + 1);
  localparam logic [ST_W-1:0]  STALL_MAX = ST_W'(STEP_TIMEOUT - 1);
  localparam logic [POS_W-1:0] WRAP_POS  = (DIR == DIR_UP) ? '0 : POS_W'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  led_q;
  logic [ST_W-1:0]   stall_q, stall_d;
  logic [SC_W-1:0]   step_q, step_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [15:0]       lap_q, lap_d;
  logic              locked_q, locked_d;
  logic              err_onehot_q, err_onehot_d;
  logic              err_step_q, err_step_d;
  logic              err_timeout_q, err_timeout_d;

  logic              led_onehot;
  logic [POS_W-1:0]  led_idx;
  logic [WIDTH-1:0]  exp_next;
  logic              transition, valid_step, timeout_hit;
  logic              new_onehot, new_step, new_timeout;

  onehot_check #(.WIDTH(WIDTH), .IDX_W(POS_W)) u_onehot (
    .vec      (led),
    .is_onehot(led_onehot),
    .idx      (led_idx)
  );

  always_comb begin
    exp_next    = (DIR == DIR_UP) ? {led_q[WIDTH-2:0], led_q[WIDTH-1]}
                                  : {led_q[0], led_q[WIDTH-1:1]};
    transition  = (led != led_q);
    valid_step  = transition && led_onehot && (led == exp_next);
    // A transition always cancels a timeout in the same cycle.
    timeout_hit = !transition && (stall_q == STALL_MAX);

    if (transition)              stall_d = '0;
    else if (stall_q == STALL_MAX) stall_d = stall_q;
    else                         stall_d = stall_q + ST_W'(1);

    state_d     = state_q;
    step_d      = step_q;
    pos_d       = pos_q;
    lap_d       = lap_q;
    new_onehot  = 1'b0;
    new_step    = 1'b0;
    new_timeout = 1'b0;

    case (state_q)
      HUNT: begin
        if (transition && led_onehot) begin
          state_d = ACQUIRE;
          step_d  = '0;
        end
      end
      ACQUIRE: begin
        if (valid_step) begin
          step_d = step_q + SC_W'(1);
          if (step_q == SC_W'(LOCK_STEPS - 1)) begin
            state_d = LOCKED;
            pos_d   = led_idx;
          end
        end else if (transition || timeout_hit) begin
          state_d = HUNT;
        end
      end
      LOCKED: begin
        if (valid_step) begin
          pos_d = led_idx;
          if (led_idx == WRAP_POS && lap_q != 16'hFFFF) lap_d = lap_q + 16'd1;
        end else if (transition && !led_onehot) begin
          new_onehot = 1'b1;
          state_d    = HUNT;
        end else if (transition) begin
          new_step = 1'b1;
          state_d  = HUNT;
        end else if (timeout_hit) begin
          new_timeout = 1'b1;
          state_d     = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase

    locked_d = (state_d == LOCKED);

    // A fresh error overrides a coincident clear.
    err_onehot_d  = (err_onehot_q  && !clr_err) || new_onehot;
    err_step_d    = (err_step_q    && !clr_err) || new_step;
    err_timeout_d = (err_timeout_q && !clr_err) || new_timeout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      led_q         <= '0;
      stall_q       <= '0;
      step_q        <= '0;
      pos_q         <= '0;
      lap_q         <= '0;
      locked_q      <= 1'b0;
      err_onehot_q  <= 1'b0;
      err_step_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      led_q         <= led;
      stall_q       <= stall_d;
      step_q        <= step_d;
      pos_q         <= pos_d;
      lap_q         <= lap_d;
      locked_q      <= locked_d;
      err_onehot_q  <= err_onehot_d;
      err_step_q    <= err_step_d;
      err_timeout_q <= err_timeout_d;
    end
  end

`ifdef LED_RIPPLE_MON_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if ((new_onehot || new_step || new_timeout) && err_count_q != 8'hFF)
      err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count_q <= 8'd0;
    else        err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`else
  assign err_count = 8'd0;
`endif

  assign locked      = locked_q;
  assign pos         = pos_q;
  assign lap_count   = lap_q;
  assign err_onehot  = err_onehot_q;
  assign err_step    = err_step_q;
  assign err_timeout = err_timeout_q;

endmodule
